decode_cycle: RTL and testbench

- Second stage of the 5-stage RV32I pipeline. Consumes fetch-stage outputs InstrD/PCD/PCPlus4D.
- Decodes control, reads the 32x32 register file (written back from W stage) and sign-extends the immediate.
- Registers the results into the ID/EX pipeline register that feeds the execute stage; supports flush for hazard/branch bubbles.

---
 rtl/riscv_pkg.sv | 56 +++++
 rtl/register_file.sv | 42 ++++
 rtl/decode_cycle.sv | 197 +++++++++++++++++++
 tb/tb_decode_cycle.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode vocabulary: opcodes, control encodings and the
// decoded-control bundle passed between the decoder and the ID/EX register.
package riscv_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [6:0] {
    OP_LW  = 7'b0000011,
    OP_SW  = 7'b0100011,
    OP_R   = 7'b0110011,
    OP_I   = 7'b0010011,
    OP_BEQ = 7'b1100011,
    OP_JAL = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // imm_en separates "no immediate" from IMM_I, which shares the 00 code.
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_e result_src;
    alu_op_e     alu_op;
    imm_src_e    imm_src;
    logic        imm_en;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// 32x32 architectural register file: x0 reads zero, two combinational read
// ports with write-first bypass, one write port on the rising edge.
module register_file #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2
);

  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic            w_wr_valid;

  assign w_wr_valid = WE3 && (A3 != '0);

  // NOTE: the storage is reset element by element so it builds from flops;
  // a reset on an array prevents mapping it onto a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_valid) begin
      r_regs[A3] <= WD3;
    end
  end

  // A same-cycle write to the register being read wins over the stored value.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (A1 != '0) RD1 = (w_wr_valid && A3 == A1) ? WD3 : r_regs[A1];
    if (A2 != '0) RD2 = (w_wr_valid && A3 == A2) ? WD3 : r_regs[A2];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extension,
// all captured in the ID/EX pipeline register (cleared on flush).
module decode_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic [REG_AW-1:0] Rs1D,
  output logic [REG_AW-1:0] Rs2D,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] RdE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E
);

  typedef struct packed {
    ctrl_t             ctrl;
    alu_ctrl_e         alu_ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } idex_t;

  ctrl_t           w_ctrl;
  alu_ctrl_e       w_alu_ctrl;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  idex_t           w_idex;
  idex_t           r_idex;

  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  register_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_register_file (
    .clk (clk),
    .rst (rst),
    .A1  (Rs1D),
    .A2  (Rs2D),
    .A3  (RdW),
    .WE3 (RegWriteW),
    .WD3 (ResultW),
    .RD1 (w_rd1),
    .RD2 (w_rd2)
  );

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_ctrl = '0;
    case (InstrD[6:0])
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
        w_ctrl.imm_src    = IMM_I;
        w_ctrl.imm_en     = 1'b1;
      end
      OP_SW: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.imm_src   = IMM_S;
        w_ctrl.imm_en    = 1'b1;
      end
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_I: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
        w_ctrl.imm_src   = IMM_I;
        w_ctrl.imm_en    = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl.branch  = 1'b1;
        w_ctrl.alu_op  = ALUOP_SUB;
        w_ctrl.imm_src = IMM_B;
        w_ctrl.imm_en  = 1'b1;
      end
      OP_JAL: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_ctrl.imm_src    = IMM_J;
        w_ctrl.imm_en     = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Only R-type may subtract via funct7[5]; addi with bit 30 set stays add.
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    case (w_ctrl.alu_op)
      ALUOP_SUB: w_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (InstrD[14:12])
          3'b000:  w_alu_ctrl = (InstrD[6:0] == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  w_alu_ctrl = ALU_SLT;
          3'b110:  w_alu_ctrl = ALU_OR;
          3'b111:  w_alu_ctrl = ALU_AND;
          default: w_alu_ctrl = ALU_ADD;
        endcase
      end
      default: w_alu_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    w_imm = '0;
    if (w_ctrl.imm_en) begin
      case (w_ctrl.imm_src)
        IMM_I: w_imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
        IMM_S: w_imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
        IMM_B: w_imm = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                        InstrD[11:8], 1'b0};
        IMM_J: w_imm = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                        InstrD[30:21], 1'b0};
        default: w_imm = '0;
      endcase
    end
  end

  always_comb begin
    w_idex          = '0;
    w_idex.ctrl     = w_ctrl;
    w_idex.alu_ctrl = w_alu_ctrl;
    w_idex.rd1      = w_rd1;
    w_idex.rd2      = w_rd2;
    w_idex.imm      = w_imm;
    w_idex.pc       = PCD;
    w_idex.pc_plus4 = PCPlus4D;
    w_idex.rd       = InstrD[11:7];
    w_idex.rs1      = Rs1D;
    w_idex.rs2      = Rs2D;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs as they stood before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idex <= '0;
    end else if (FlushE) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_idex;
    end
  end

  assign RegWriteE   = r_idex.ctrl.reg_write;
  assign MemWriteE   = r_idex.ctrl.mem_write;
  assign JumpE       = r_idex.ctrl.jump;
  assign BranchE     = r_idex.ctrl.branch;
  assign ALUSrcE     = r_idex.ctrl.alu_src;
  assign ResultSrcE  = r_idex.ctrl.result_src;
  assign ALUControlE = r_idex.alu_ctrl;
  assign RD1E        = r_idex.rd1;
  assign RD2E        = r_idex.rd2;
  assign ImmExtE     = r_idex.imm;
  assign PCE         = r_idex.pc;
  assign PCPlus4E    = r_idex.pc_plus4;
  assign RdE         = r_idex.rd;
  assign Rs1E        = r_idex.rs1;
  assign Rs2E        = r_idex.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed scenarios plus randomized traffic compared
// against an instruction-level reference model of decode and the register file.
module tb_decode_cycle;

  typedef logic [184:0] e_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW, Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_regs [32];

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
  );

  function automatic e_vec_t dut_e();
    return {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
            RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                         input logic [4:0] rdw, input logic [31:0] res);
    if (a == 0) return 32'h0;
    if (we && rdw == a) return res;
    return m_regs[a];
  endfunction

  function automatic logic [2:0] m_funct_alu(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'd0:    return sub_ok ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected E-side values for one instruction, from the ISA rules directly.
  function automatic e_vec_t model_e(input logic [31:0] ins, input logic [31:0] pc, pc4,
                                     input logic we, input logic [4:0] rdw,
                                     input logic [31:0] res, input logic flush);
    int signed   s;
    logic        rw, mw, jp, br, as;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
    logic [31:0] imm, sgn;
    s = $signed(ins);
    sgn = 32'(s >>> 31);
    {rw, mw, jp, br, as, rsrc, alu, imm} = '0;
    case (ins[6:0])
      7'b0000011: begin rw = 1; as = 1; rsrc = 2'b01; imm = 32'(s >>> 20); end
      7'b0100011: begin mw = 1; as = 1; imm = 32'(s >>> 25) * 32 + 32'(ins[11:7]); end
      7'b0110011: begin rw = 1; alu = m_funct_alu(ins[14:12], ins[30]); end
      7'b0010011: begin rw = 1; as = 1; imm = 32'(s >>> 20); alu = m_funct_alu(ins[14:12], 1'b0); end
      7'b1100011: begin
        br = 1; alu = 3'd1;
        imm = sgn * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
      end
      7'b1101111: begin
        rw = 1; jp = 1; rsrc = 2'b10;
        imm = sgn * (1 << 20) + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
      end
      default: ;
    endcase
    if (flush) return '0;
    return {rw, mw, jp, br, as, rsrc, alu,
            m_read(ins[19:15], we, rdw, res), m_read(ins[24:20], we, rdw, res),
            imm, pc, pc4, ins[11:7], ins[19:15], ins[24:20]};
  endfunction

  // Applies one cycle of inputs at posedge+1, returns the expected E vector
  // and the combinational source fields seen before the edge.
  task automatic drive(input logic [31:0] ins, pc, input logic we, input logic [4:0] rdw,
                       input logic [31:0] res, input logic flush,
                       output e_vec_t exp, output logic [4:0] rs1d, rs2d);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 4;
    RegWriteW = we; RdW = rdw; ResultW = res; FlushE = flush;
    exp = model_e(ins, pc, pc + 4, we, rdw, res, flush);
    if (we && rdw != 0) m_regs[rdw] = res;
    #2;
    rs1d = Rs1D; rs2d = Rs2D;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    e_vec_t exp; logic [4:0] a, b;
    rst = 0; InstrD = 32'h00500093; PCD = 32'h100; PCPlus4D = 32'h104;
    RegWriteW = 1; RdW = 5'd7; ResultW = 32'hDEAD; FlushE = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (dut_e() !== '0) begin n_fail++; $display("FAIL reset_hold got=%h exp=0", dut_e()); end
    rst = 1;
    n_checks++; if (dut_e() !== '0) begin n_fail++; $display("FAIL reset_release got=%h exp=0", dut_e()); end
    drive(32'h00500093, 32'h100, 0, 0, 0, 0, exp, a, b);
    n_checks++; if ({RegWriteE, ALUSrcE} !== 2'b11) begin n_fail++; $display("FAIL addi_ctrl got=%b exp=11", {RegWriteE, ALUSrcE}); end
    n_checks++; if (ImmExtE !== 32'd5) begin n_fail++; $display("FAIL addi_imm got=%h exp=5", ImmExtE); end
    n_checks++; if (RdE !== 5'd1 || ALUControlE !== 3'b000) begin n_fail++; $display("FAIL addi_rd_alu got=%0d/%b exp=1/000", RdE, ALUControlE); end
    n_checks++; if (dut_e() !== exp) begin n_fail++; $display("FAIL addi_full got=%h exp=%h", dut_e(), exp); end
    // register x7 written during reset must not have landed
    drive(32'h00700033, 32'h104, 0, 0, 0, 0, exp, a, b);
    n_checks++; if (RD1E !== 32'h0 || RD2E !== 32'h0) begin n_fail++; $display("FAIL reset_lost_write got=%h/%h exp=0/0", RD1E, RD2E); end
  endtask

  task automatic test_writeback_read();
    e_vec_t exp; logic [4:0] a, b;
    drive(32'h0, 32'h200, 1, 5'd2, 32'hAA, 0, exp, a, b);
    n_checks++; if (dut_e() !== exp) begin n_fail++; $display("FAIL nop_full got=%h exp=%h", dut_e(), exp); end
    drive(32'h002081B3, 32'h204, 0, 0, 0, 0, exp, a, b);
    n_checks++; if (RD2E !== 32'hAA) begin n_fail++; $display("FAIL wb_read got=%h exp=000000aa", RD2E); end
    n_checks++; if (ALUControlE !== 3'b000 || ImmExtE !== 0) begin n_fail++; $display("FAIL add_alu got=%b/%h exp=000/0", ALUControlE, ImmExtE); end
    drive(32'h402081B3, 32'h208, 0, 0, 0, 0, exp, a, b);
    n_checks++; if (ALUControlE !== 3'b001) begin n_fail++; $display("FAIL sub_alu got=%b exp=001", ALUControlE); end
    n_checks++; if (dut_e() !== exp) begin n_fail++; $display("FAIL sub_full got=%h exp=%h", dut_e(), exp); end
  endtask

  task automatic test_bypass_x0();
    e_vec_t exp; logic [4:0] a, b;
    drive(32'h002081B3, 32'h300, 1, 5'd2, 32'h1234, 0, exp, a, b);
    n_checks++; if (RD2E !== 32'h1234) begin n_fail++; $display("FAIL bypass got=%h exp=00001234", RD2E); end
    drive(32'h00000033, 32'h304, 1, 5'd0, 32'hFFFF, 0, exp, a, b);
    n_checks++; if (RD1E !== 0 || RD2E !== 0) begin n_fail++; $display("FAIL x0_bypass got=%h/%h exp=0/0", RD1E, RD2E); end
    drive(32'h00000033, 32'h308, 0, 0, 0, 0, exp, a, b);
    n_checks++; if (RD1E !== 0 || RD2E !== 0) begin n_fail++; $display("FAIL x0_read got=%h/%h exp=0/0", RD1E, RD2E); end
  endtask

  task automatic test_immediates();
    e_vec_t exp; logic [4:0] a, b;
    drive(32'hFE112E23, 32'h400, 0, 0, 0, 0, exp, a, b);
    n_checks++; if (MemWriteE !== 1 || ImmExtE !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL sw got=%b/%h exp=1/fffffffc", MemWriteE, ImmExtE); end
    n_checks++; if (dut_e() !== exp) begin n_fail++; $display("FAIL sw_full got=%h exp=%h", dut_e(), exp); end
    drive(32'hFE0008E3, 32'h404, 0, 0, 0, 0, exp, a, b);
    n_checks++; if (BranchE !== 1 || ALUControlE !== 3'b001 || ImmExtE !== 32'hFFFFFFF0) begin
      n_fail++; $display("FAIL beq got=%b/%b/%h exp=1/001/fffffff0", BranchE, ALUControlE, ImmExtE); end
    drive(32'h008000EF, 32'h408, 0, 0, 0, 0, exp, a, b);
    n_checks++; if (JumpE !== 1 || ResultSrcE !== 2'b10 || ImmExtE !== 32'd8) begin
      n_fail++; $display("FAIL jal got=%b/%b/%h exp=1/10/8", JumpE, ResultSrcE, ImmExtE); end
    n_checks++; if (dut_e() !== exp) begin n_fail++; $display("FAIL jal_full got=%h exp=%h", dut_e(), exp); end
  endtask

  task automatic test_flush();
    e_vec_t exp; logic [4:0] a, b;
    drive(32'h0000A103, 32'h500, 1, 5'd5, 32'hCAFE, 1, exp, a, b);
    n_checks++; if (dut_e() !== '0) begin n_fail++; $display("FAIL flush got=%h exp=0", dut_e()); end
    drive(32'h000280B3, 32'h504, 0, 0, 0, 0, exp, a, b);
    n_checks++; if (RD1E !== 32'hCAFE) begin n_fail++; $display("FAIL flush_wb got=%h exp=0000cafe", RD1E); end
  endtask

  task automatic test_random();
    e_vec_t exp; logic [4:0] a, b;
    logic [6:0] ops [7];
    logic [31:0] ins, r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0};
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      ops[6] = 7'($urandom);
      ins = {r[31:7], ops[$urandom_range(0, 6)]};
      drive(ins, $urandom, 1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
            $urandom_range(0, 9) == 0, exp, a, b);
      n_checks++; if (a !== ins[19:15] || b !== ins[24:20]) begin
        n_fail++; $display("FAIL rs_d[%0d] got=%0d/%0d exp=%0d/%0d", i, a, b, ins[19:15], ins[24:20]); end
      n_checks++; if (dut_e() !== exp) begin
        n_fail++; $display("FAIL random[%0d] ins=%h got=%h exp=%h", i, ins, dut_e(), exp); end
    end
  endtask

  task automatic test_async_reset();
    e_vec_t exp; logic [4:0] a, b;
    InstrD = 32'h0000A103; RegWriteW = 1; RdW = 5'd9; ResultW = 32'h5555; FlushE = 0;
    @(posedge clk); #3;
    n_checks++; if (dut_e() === '0) begin n_fail++; $display("FAIL async_precond got=0 exp=nonzero"); end
    rst = 0; #1;
    n_checks++; if (dut_e() !== '0) begin n_fail++; $display("FAIL async_reset got=%h exp=0", dut_e()); end
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    @(posedge clk); #1;
    rst = 1;
    for (int i = 1; i < 32; i++) begin
      drive({7'd0, 5'(32 - i), 5'(i), 3'd0, 5'd0, 7'b0110011}, 32'h600, 0, 0, 0, 0, exp, a, b);
      n_checks++; if (RD1E !== 0 || RD2E !== 0 || dut_e() !== exp) begin
        n_fail++; $display("FAIL regs_cleared[x%0d] got=%h/%h exp=0/0", i, RD1E, RD2E); end
    end
  endtask

  initial begin
    test_reset();
    test_writeback_read();
    test_bypass_x0();
    test_immediates();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
